dcache_port_arbiter: RTL and testbench
======================================

// Module: dcache_port_arbiter
// PURPOSE
//  Shares the single core-side dcache port (core2dcache_* / dcache2core_*) between NUM_REQ
//  memory requesters (e.g. the load/store pipe and a store-drain path). Round-robin grant,
//  one outstanding access at a time. Routes the load response back to the granted requester.
// PARAMETERS
//  NUM_REQ    2    number of requesters (>=2)
//  TIMEOUT    64   cycles to wait for dcache2core_data_valid (used only with DCACHE_ARB_TIMEOUT_EN)
// PORTS
//  clock                   in   1             core clock
//  reset                   in   1             asynchronous, active-high
//  req_valid               in   NUM_REQ       requester i has a request; held until req_ready[i]
//  req_ready               out  NUM_REQ       one-hot grant (combinational, IDLE only)
//  req_addr                in   NUM_REQ*32    byte address per requester
//  req_data                in   NUM_REQ*64    store data per requester
//  req_we                  in   NUM_REQ       1 = store, 0 = load
//  req_size                in   NUM_REQ x mem_size_t   access size
//  resp_valid              out  NUM_REQ       one-cycle completion pulse to owner
//  resp_data               out  64            load data (raw, unextended); 0 for stores
//  resp_err                out  1             timeout flag, valid with resp_valid (0 if macro off)
//  core2dcache_addr        out  32            registered address to dcache
//  core2dcache_data        out  64            registered store data
//  core2dcache_data_we     out  1             registered write enable
//  core2dcache_data_size   out  mem_size_t    registered size
//  dcache2core_data        in   64            load data from dcache
//  dcache2core_data_valid  in   1             load data valid
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0. Reset mid-access
//    aborts it: no resp_valid is issued; a dcache response arriving afterwards in IDLE is ignored.
//  - FSM IDLE/BUSY. IDLE: winner = first i with req_valid[i], searching from rr_ptr upward with
//    wrap. req_ready[winner]=1 same cycle; at the edge: latch owner, drive core2dcache_* from
//    winner's fields, rr_ptr <= (winner+1) mod NUM_REQ, go BUSY. No req_valid: outputs unchanged.
//  - BUSY: req_ready=0. Store (we=1): completes in first BUSY cycle. Load: completes in cycle
//    dcache2core_data_valid=1 (data valid in same cycle BUSY is entered is not accepted:
//    earliest is first BUSY cycle). On completion: resp_valid[owner]=1 for that cycle
//    (combinational), resp_data=dcache2core_data for loads, 0 for stores; next edge -> IDLE,
//    core2dcache_* cleared to 0.
//  - Grant latency 0 cycles; store turnaround 2 cycles/request; one idle bubble between accesses.
//  - dcache2core_data_valid in IDLE ignored. resp_valid is never multi-hot.
//  - rr_ptr advances only on grant; a requester that drops req_valid before grant loses nothing.
// CONFIGURATION
//  DCACHE_ARB_TIMEOUT_EN defined: counter counts BUSY load cycles; on reaching TIMEOUT with no
//   data valid, resp_valid[owner]=1, resp_err=1, resp_data=0, return to IDLE. Counter clears on
//   entering BUSY. Undefined: no counter, loads wait indefinitely, resp_err tied 0.
// STRUCTURE
//  - Shared package: mem_size_t (existing), arb_state_t {ARB_IDLE, ARB_BUSY}.
//  - One sub-module: rr_picker (NUM_REQ-wide round-robin find-first from pointer, combinational,
//    outputs one-hot grant + index).
// TESTING
//  1 Reset: assert reset mid-load -> all outputs 0, later data_valid gives no resp_valid.
//  2 Single store: req0 we=1 addr=0x100 data=0xAB size=WORD -> ready0 cyc0, c2d_addr=0x100,
//    we=1 cyc1, resp_valid[0] cyc1, IDLE cyc2.
//  3 Load latency: req1 load addr=0x200, data_valid 3 cycles later data=0xDEADBEEF ->
//    resp_valid[1] in that cycle, resp_data=0xDEADBEEF, resp_err=0.
//  4 Fairness: req0,req1 held valid continuously, stores -> grants alternate 0,1,0,1 from reset.
//  5 Simultaneous: data_valid in IDLE while req0 load arrives -> ignored, req0 waits for next.
//  6 (DCACHE_ARB_TIMEOUT_EN, TIMEOUT=8) load never answered -> resp_valid[owner], resp_err=1
//    at 8th BUSY cycle, next grant proceeds.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// rtl/dcache_port_arbiter_pkg.sv - shared types for the dcache port arbiter
package dcache_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'd0,
    MEM_HALF  = 2'd1,
    MEM_WORD  = 2'd2,
    MEM_DWORD = 2'd3
  } mem_size_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// rtl/dcache_port_arbiter_if.sv - requester and dcache-side signal bundle for the arbiter
interface dcache_port_arbiter_if
  import dcache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_we;
  mem_size_t                 req_size [NUM_REQ];

  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;

  logic [ADDR_W-1:0]         core2dcache_addr;
  logic [DATA_W-1:0]         core2dcache_data;
  logic                      core2dcache_data_we;
  mem_size_t                 core2dcache_data_size;
  logic [DATA_W-1:0]         dcache2core_data;
  logic                      dcache2core_data_valid;

  // master: requesters plus dcache model; slave: the arbiter
  modport master (
    output req_valid, req_addr, req_data, req_we, req_size,
    output dcache2core_data, dcache2core_data_valid,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  core2dcache_addr, core2dcache_data, core2dcache_data_we, core2dcache_data_size
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_we, req_size,
    input  dcache2core_data, dcache2core_data_valid,
    output req_ready, resp_valid, resp_data, resp_err,
    output core2dcache_addr, core2dcache_data, core2dcache_data_we, core2dcache_data_size
  );

endinterface

// File: rtl/dcache_port_arbiter_rr_picker.sv
// rtl/dcache_port_arbiter_rr_picker.sv - combinational round-robin find-first from a pointer
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int             cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    // scan ptr, ptr+1, ... with wrap; the first hit wins
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - round-robin sharing of the core dcache port, one access in flight
// Optional load timeout enabled by defining DCACHE_ARB_TIMEOUT_EN.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  dcache_port_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               we_q;
  mem_size_t          size_q;

  logic               done;
  logic               timed_out;
  logic [NUM_REQ-1:0] req_ready_d;
  logic [NUM_REQ-1:0] resp_valid_d;
  logic [DATA_W-1:0]  resp_data_d;
  logic               resp_err_d;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any       (win_any)
  );

`ifdef DCACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt_q;

  // holds zero in IDLE so every access starts its count fresh
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (state_q == ARB_IDLE) begin
      to_cnt_q <= '0;
    end else if (!we_q) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timed_out = (state_q == ARB_BUSY) && !we_q && !bus.dcache2core_data_valid &&
                     (to_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    done         = 1'b0;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (win_any && !reset) begin
          req_ready_d = win_onehot;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        done = we_q || bus.dcache2core_data_valid || timed_out;
        if (done) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_err_d            = timed_out;
          if (!we_q && bus.dcache2core_data_valid) begin
            resp_data_d = bus.dcache2core_data;
          end
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= MEM_BYTE;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && win_any) begin
        owner_q  <= win_idx;
        addr_q   <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
        data_q   <= bus.req_data[win_idx*DATA_W +: DATA_W];
        we_q     <= bus.req_we[win_idx];
        size_q   <= bus.req_size[win_idx];
        rr_ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (state_q == ARB_BUSY && done) begin
        addr_q <= '0;
        data_q <= '0;
        we_q   <= 1'b0;
        size_q <= MEM_BYTE;
      end
    end
  end

  assign bus.req_ready             = req_ready_d;
  assign bus.resp_valid            = resp_valid_d;
  assign bus.resp_data             = resp_data_d;
  assign bus.resp_err              = resp_err_d;
  assign bus.core2dcache_addr      = addr_q;
  assign bus.core2dcache_data      = data_q;
  assign bus.core2dcache_data_we   = we_q;
  assign bus.core2dcache_data_size = size_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - scoreboard bench for dcache_port_arbiter (DCACHE_ARB_TIMEOUT_EN aware)
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [NUM_REQ-1:0] who;
    logic [63:0]        data;
    logic               err;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb [$];

  always #5 clock = ~clock;

  dcache_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  dcache_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic [NUM_REQ-1:0] who, input logic [63:0] data, input logic err);
    exp_t e;
    e.who  = who;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [31:0] addr,
                         input logic [63:0] data, input mem_size_t sz);
    bus.req_valid[i]            = v;
    bus.req_we[i]               = we;
    bus.req_addr[i*32 +: 32]    = addr;
    bus.req_data[i*64 +: 64]    = data;
    bus.req_size[i]             = sz;
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && bus.resp_valid != '0) begin
        check("resp_onehot", 64'($countones(bus.resp_valid)), 64'd1);
        if (sb.size() == 0) begin
          check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_owner", 64'(bus.resp_valid), 64'(e.who));
          check("resp_data", bus.resp_data, e.data);
          check("resp_err", 64'(bus.resp_err), 64'(e.err));
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_addr"}, 64'(bus.core2dcache_addr), 64'd0);
    check({tag, "_wdata"}, bus.core2dcache_data, 64'd0);
    check({tag, "_we"}, 64'(bus.core2dcache_data_we), 64'd0);
    check({tag, "_size"}, 64'(bus.core2dcache_data_size), 64'd0);
    check({tag, "_err"}, 64'(bus.resp_err), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_size[i] = MEM_BYTE;
    bus.dcache2core_data       = '0;
    bus.dcache2core_data_valid = 1'b0;

    fork
      monitor();
    join_none

    @(negedge clock);
    @(negedge clock);
    check_idle_outputs("reset");
    drive_edge();
    reset = 1'b0;

    // single store from requester 0
    drive_edge();
    set_req(0, 1'b1, 1'b1, 32'h100, 64'hAB, MEM_WORD);
    @(negedge clock);
    check("st_ready", 64'(bus.req_ready), 64'b01);
    expect_resp(2'b01, 64'h0, 1'b0);
    drive_edge();
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
    @(negedge clock);
    check("st_addr", 64'(bus.core2dcache_addr), 64'h100);
    check("st_we", 64'(bus.core2dcache_data_we), 64'd1);
    check("st_wdata", bus.core2dcache_data, 64'hAB);
    check("st_size", 64'(bus.core2dcache_data_size), 64'(MEM_WORD));
    check("st_busy_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clock);
    check("st_cleared_addr", 64'(bus.core2dcache_addr), 64'd0);

    // load from requester 1, answered three cycles after grant
    drive_edge();
    set_req(1, 1'b1, 1'b0, 32'h200, 64'h0, MEM_DWORD);
    @(negedge clock);
    check("ld_ready", 64'(bus.req_ready), 64'b10);
    expect_resp(2'b10, 64'hDEADBEEF, 1'b0);
    drive_edge();
    set_req(1, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
    @(negedge clock);
    check("ld_addr", 64'(bus.core2dcache_addr), 64'h200);
    check("ld_we", 64'(bus.core2dcache_data_we), 64'd0);
    drive_edge();
    drive_edge();
    bus.dcache2core_data_valid = 1'b1;
    bus.dcache2core_data       = 64'hDEADBEEF;
    drive_edge();
    bus.dcache2core_data_valid = 1'b0;
    bus.dcache2core_data       = 64'h0;

    // stale data_valid in IDLE alongside a new load must not complete it
    drive_edge();
    set_req(0, 1'b1, 1'b0, 32'h400, 64'h0, MEM_WORD);
    bus.dcache2core_data_valid = 1'b1;
    bus.dcache2core_data       = 64'h1111;
    @(negedge clock);
    check("sim_ready", 64'(bus.req_ready), 64'b01);
    expect_resp(2'b01, 64'h2222, 1'b0);
    drive_edge();
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
    bus.dcache2core_data_valid = 1'b0;
    bus.dcache2core_data       = 64'h0;
    @(negedge clock);
    check("sim_wait", 64'(bus.resp_valid), 64'd0);
    drive_edge();
    bus.dcache2core_data_valid = 1'b1;
    bus.dcache2core_data       = 64'h2222;
    drive_edge();
    bus.dcache2core_data_valid = 1'b0;
    bus.dcache2core_data       = 64'h0;

    // reset in the middle of a load aborts it
    drive_edge();
    set_req(1, 1'b1, 1'b0, 32'h300, 64'h0, MEM_WORD);
    @(negedge clock);
    check("abort_ready", 64'(bus.req_ready), 64'b10);
    drive_edge();
    set_req(1, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
    @(negedge clock);
    check("abort_addr", 64'(bus.core2dcache_addr), 64'h300);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    drive_edge();
    reset = 1'b0;
    bus.dcache2core_data_valid = 1'b1;
    bus.dcache2core_data       = 64'h5555;
    @(negedge clock);
    check("abort_late_dv0", 64'(bus.resp_valid), 64'd0);
    drive_edge();
    @(negedge clock);
    check("abort_late_dv1", 64'(bus.resp_valid), 64'd0);
    drive_edge();
    bus.dcache2core_data_valid = 1'b0;
    bus.dcache2core_data       = 64'h0;

    // fairness from reset: both hold stores, grants alternate 0,1,0,1
    set_req(0, 1'b1, 1'b1, 32'h600, 64'h11, MEM_WORD);
    set_req(1, 1'b1, 1'b1, 32'h700, 64'h22, MEM_HALF);
    for (int g = 0; g < 4; g++) begin
      @(negedge clock);
      check("fair_grant", 64'(bus.req_ready), (g % 2 == 0) ? 64'b01 : 64'b10);
      expect_resp((g % 2 == 0) ? 2'b01 : 2'b10, 64'h0, 1'b0);
      @(negedge clock);
      check("fair_addr", 64'(bus.core2dcache_addr), (g % 2 == 0) ? 64'h600 : 64'h700);
    end
    drive_edge();
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
    set_req(1, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);

`ifdef DCACHE_ARB_TIMEOUT_EN
    // unanswered load times out on its 8th BUSY cycle, next grant proceeds
    drive_edge();
    set_req(0, 1'b1, 1'b0, 32'h500, 64'h0, MEM_WORD);
    @(negedge clock);
    check("to_ready", 64'(bus.req_ready), 64'b01);
    expect_resp(2'b01, 64'h0, 1'b1);
    drive_edge();
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clock);
      check("to_cycle", 64'(bus.resp_valid), (c == TIMEOUT) ? 64'b01 : 64'd0);
    end
    drive_edge();
    set_req(1, 1'b1, 1'b1, 32'h580, 64'h33, MEM_WORD);
    @(negedge clock);
    check("to_next_ready", 64'(bus.req_ready), 64'b10);
    expect_resp(2'b10, 64'h0, 1'b0);
    drive_edge();
    set_req(1, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
`else
    // without the timeout a load simply keeps waiting
    drive_edge();
    set_req(0, 1'b1, 1'b0, 32'h500, 64'h0, MEM_WORD);
    @(negedge clock);
    check("wait_ready", 64'(bus.req_ready), 64'b01);
    drive_edge();
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0, MEM_BYTE);
    for (int c = 1; c <= 3 * TIMEOUT; c++) begin
      @(negedge clock);
      check("wait_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    expect_resp(2'b01, 64'h7777, 1'b0);
    drive_edge();
    bus.dcache2core_data_valid = 1'b1;
    bus.dcache2core_data       = 64'h7777;
    drive_edge();
    bus.dcache2core_data_valid = 1'b0;
    bus.dcache2core_data       = 64'h0;
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
